// File: rtl/risc_core_hs.sv
// Multi-cycle RISC core: 16-bit instruction encoding, eight DATA_W-wide registers,
// one shared instruction/data memory port with a mem_ready handshake.
module risc_core_hs #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] read_data,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        m_cmd,
  output logic              h
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_pc, r_addr;
  logic [DATA_W-1:0] r_regs [8];
  logic [DATA_W-1:0] r_result, r_wdata;
  logic [15:0]       r_ir;
  logic [2:0]        r_dest;
  logic              r_n, r_z, r_v;

  logic [2:0]        w_opcode, w_rn, w_rd, w_rm, w_cond;
  logic [1:0]        w_op, w_sh;
  logic [DATA_W-1:0] w_sximm8, w_rnVal, w_rdVal, w_rmVal, w_shifted, w_diff;
  logic [ADDR_W-1:0] w_sximm5, w_effAddr, w_brTarget;
  logic              w_isMovImm, w_isMovReg, w_isAlu, w_isCmp, w_isLdr, w_isStr;
  logic              w_isB, w_isBl, w_isBx, w_isHalt, w_taken;

  assign w_opcode   = r_ir[15:13];
  assign w_op       = r_ir[12:11];
  assign w_rn       = r_ir[10:8];
  assign w_rd       = r_ir[7:5];
  assign w_sh       = r_ir[4:3];
  assign w_rm       = r_ir[2:0];
  assign w_cond     = r_ir[10:8];
  assign w_sximm8   = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
  assign w_sximm5   = {{(ADDR_W-5){r_ir[4]}}, r_ir[4:0]};
  assign w_rnVal    = r_regs[w_rn];
  assign w_rdVal    = r_regs[w_rd];
  assign w_rmVal    = r_regs[w_rm];
  assign w_diff     = w_rnVal - w_shifted;
  assign w_effAddr  = w_rnVal[ADDR_W-1:0] + w_sximm5;
  assign w_brTarget = r_pc + w_sximm8[ADDR_W-1:0];

  assign w_isMovImm = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_isMovReg = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_isAlu    = (w_opcode == 3'b101) && (w_op != 2'b01);
  assign w_isCmp    = (w_opcode == 3'b101) && (w_op == 2'b01);
  assign w_isLdr    = (w_opcode == 3'b011) && (w_op == 2'b00);
  assign w_isStr    = (w_opcode == 3'b100) && (w_op == 2'b00);
  assign w_isB      = (w_opcode == 3'b001) && (w_op == 2'b00);
  assign w_isBl     = (w_opcode == 3'b010) && (w_op == 2'b11);
  assign w_isBx     = (w_opcode == 3'b010) && (w_op == 2'b00);
  assign w_isHalt   = (w_opcode == 3'b111);

  always_comb begin
    w_shifted = w_rmVal;
    case (w_sh)
      2'b01:   w_shifted = {w_rmVal[DATA_W-2:0], 1'b0};
      2'b10:   w_shifted = {1'b0, w_rmVal[DATA_W-1:1]};
      2'b11:   w_shifted = {w_rmVal[DATA_W-1], w_rmVal[DATA_W-1:1]};
      default: w_shifted = w_rmVal;
    endcase
  end

  always_comb begin
    case (w_cond)
      3'b000:  w_taken = 1'b1;
      3'b001:  w_taken = r_z;
      3'b010:  w_taken = ~r_z;
      3'b011:  w_taken = r_n ^ r_v;
      3'b100:  w_taken = (r_n ^ r_v) | r_z;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RST;
    else       r_state <= w_next;
  end

  // Bus outputs decode from state only, so a reset drops any command at once.
  always_comb begin
    w_next     = r_state;
    m_cmd      = CMD_NONE;
    mem_addr   = '0;
    write_data = '0;
    h          = 1'b0;
    case (r_state)
      S_RST:    w_next = S_FETCH;
      S_FETCH: begin
        m_cmd    = CMD_READ;
        mem_addr = r_pc;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: w_next = w_isHalt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (w_isMovImm || w_isMovReg || w_isAlu) w_next = S_WB;
        else if (w_isLdr || w_isStr)             w_next = S_MEM;
        else                                     w_next = S_FETCH;
      end
      S_MEM: begin
        m_cmd    = w_isStr ? CMD_WRITE : CMD_READ;
        mem_addr = r_addr;
        if (w_isStr) write_data = r_wdata;
        if (mem_ready) w_next = w_isStr ? S_FETCH : S_WB;
      end
      S_WB:     w_next = S_FETCH;
      S_HALT: begin
        h      = 1'b1;
        w_next = S_HALT;
      end
      default:  w_next = S_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_addr   <= '0;
      r_result <= '0;
      r_wdata  <= '0;
      r_dest   <= '0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_ir <= read_data[15:0];
        S_DECODE: r_pc <= r_pc + 1'b1;
        S_EXEC: begin
          if (w_isMovImm) begin
            r_result <= w_sximm8;
            r_dest   <= w_rn;
          end else if (w_isMovReg) begin
            r_result <= w_shifted;
            r_dest   <= w_rd;
          end else if (w_isAlu) begin
            r_dest <= w_rd;
            case (w_op)
              2'b00:   r_result <= w_rnVal + w_shifted;
              2'b10:   r_result <= w_rnVal & w_shifted;
              default: r_result <= ~w_shifted;
            endcase
          end else if (w_isCmp) begin
            r_n <= w_diff[DATA_W-1];
            r_z <= (w_diff == '0);
            r_v <= (w_rnVal[DATA_W-1] != w_shifted[DATA_W-1]) &&
                   (w_diff[DATA_W-1] != w_rnVal[DATA_W-1]);
          end else if (w_isLdr || w_isStr) begin
            r_addr  <= w_effAddr;
            r_wdata <= w_rdVal;
            r_dest  <= w_rd;
          end else if (w_isB) begin
            if (w_taken) r_pc <= w_brTarget;
          end else if (w_isBl) begin
            r_regs[7] <= DATA_W'(r_pc);
            r_pc      <= w_brTarget;
          end else if (w_isBx) begin
            r_pc <= w_rdVal[ADDR_W-1:0];
          end
        end
        S_MEM:    if (mem_ready && w_isLdr) r_result <= read_data;
        S_WB:     r_regs[r_dest] <= r_result;
        default:  ;
      endcase
    end
  end

endmodule
